// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample playback controller.
// Holds the controller FSM encoding and the PWM mid-scale silence level.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        PAUSE,
        DRAIN
    } state_t;

    localparam logic [15:0] SILENCE = 16'h8000;

endpackage

// File: rtl/sample_rate_div.sv
// Sample-period counter: counts 0..CYC_PER_SAMPLE-1 while run is high.
// wrap marks the last cycle of a period; clr restarts the period.
module sample_rate_div #(
    parameter int CYC_PER_SAMPLE = 4095
) (
    input  logic pwm_clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic wrap
);

    localparam int CW = (CYC_PER_SAMPLE > 1) ? $clog2(CYC_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYC_PER_SAMPLE - 1);

    logic [CW-1:0] cnt;

    assign wrap = run && (cnt == LAST);

    always_ff @(posedge pwm_clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/audio_play_ctrl.sv
// Audio playback controller: fetches samples from memory one period ahead
// and presents them to the PWM player at a fixed sample rate.
module audio_play_ctrl
    import audio_pkg::*;
#(
    parameter int CYC_PER_SAMPLE = 4095,
    parameter int ADDR_W         = 16
) (
    input  logic              pwm_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [15:0]       pwm_data,
    output logic              sample_tick,
    output logic              busy,
    output logic              done
);

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic              loop_q;
    logic [15:0]       prefetch;

    logic wrap;
    logic run;
    logic clr;
    logic go;
    logic abort;
    logic capture;
    logic advance;
    logic finish;
    logic at_end;

    // stop outranks everything but reset; start is only honoured from IDLE
    assign abort   = stop && (state != IDLE);
    assign go      = (state == IDLE) && start && !stop;
    assign at_end  = (addr == end_q);
    assign run     = !abort && ((state inside {FETCH, WAIT, DRAIN}) ||
                                ((state == PLAY) && !pause));
    assign clr     = go || abort;
    assign capture = (state == WAIT) && !abort;
    assign advance = (state == PLAY) && !abort && !pause && wrap;
    assign finish  = (state == DRAIN) && !abort && wrap;

    sample_rate_div #(
        .CYC_PER_SAMPLE(CYC_PER_SAMPLE)
    ) u_div (
        .pwm_clk(pwm_clk),
        .rst    (rst),
        .run    (run),
        .clr    (clr),
        .wrap   (wrap)
    );

    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (go) state_nx = FETCH;
                FETCH:   state_nx = WAIT;
                WAIT:    state_nx = PLAY;
                PLAY: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end else if (wrap) begin
                        state_nx = (!at_end || loop_q) ? FETCH : DRAIN;
                    end
                end
                PAUSE:   if (!pause) state_nx = PLAY;
                DRAIN:   if (wrap) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        mem_rd   = 1'b0;
        mem_addr = '0;
        if (state == FETCH) begin
            mem_rd   = !abort && !rst;
            mem_addr = addr;
        end
    end

    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            addr        <= '0;
            start_q     <= '0;
            end_q       <= '0;
            loop_q      <= 1'b0;
            prefetch    <= SILENCE;
            pwm_data    <= SILENCE;
            sample_tick <= 1'b0;
            done        <= 1'b0;
        end else begin
            sample_tick <= advance;
            done        <= finish;
            if (go) begin
                start_q <= start_addr;
                end_q   <= end_addr;
                loop_q  <= loop_en;
                addr    <= start_addr;
            end
            if (capture) begin
                prefetch <= mem_data;
            end
            if (advance) begin
                pwm_data <= prefetch;
                if (!at_end) begin
                    addr <= addr + ADDR_W'(1);
                end else if (loop_q) begin
                    addr <= start_q;
                end
            end
            if (finish || abort) begin
                pwm_data <= SILENCE;
            end
        end
    end

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Bench for audio_play_ctrl: directed and random playback runs compared
// cycle by cycle against a schedule computed from the sample-period rules.
module tb_audio_play_ctrl;

    localparam int N = 8;
    localparam logic [15:0] SIL = 16'h8000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic        loop_en;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] pwm_data;
    logic        sample_tick;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    audio_play_ctrl #(
        .CYC_PER_SAMPLE(N),
        .ADDR_W        (16)
    ) dut (
        .pwm_clk    (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .loop_en    (loop_en),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .pwm_data   (pwm_data),
        .sample_tick(sample_tick),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] val(input logic [15:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h1000;
        return p[15:0];
    endfunction

    // memory: data valid only the cycle after a read, garbage otherwise
    always @(posedge clk) begin
        if (mem_rd) mem_data <= val(mem_addr);
        else        mem_data <= 16'($urandom);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int off,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s off=%0d observed=%h expected=%h",
                   tag, off, obs, exp);
        end
    endtask

    // One playback run. pk: pause after tick pk (-1 none) for pl cycles;
    // sk: stop one cycle after tick sk (-1 none); rd: reset in DRAIN.
    task automatic play(input logic [15:0] s, input logic [15:0] e,
                        input bit lp, input int pk, input int pl,
                        input int sk, input bit rd);
        int tt[32];
        int rt[32];
        logic [15:0] ta[32];
        logic [15:0] d;
        logic [15:0] ep;
        logic [15:0] ea;
        int n, nt, nf, pp, so, ro, eo;
        bit nat, et, er;
        d  = e - s;
        n  = int'(d) + 1;
        nt = (sk >= 0) ? sk + 1 : n;
        for (int j = 0; j <= nt; j++) begin
            ta[j] = s + 16'(lp ? j % n : j);
            tt[j] = N * (j + 1) + ((pk >= 0 && j > pk) ? pl + 1 : 0);
            rt[j] = (j == 0) ? 0 : tt[j-1];
        end
        nf  = (sk >= 0 && (lp || nt < n)) ? nt + 1 : nt;
        pp  = (pk >= 0) ? tt[pk] + 3 : -100;
        so  = -1;
        ro  = -1;
        nat = 1'b0;
        if (sk >= 0) begin
            so = tt[sk] + 1;
            eo = so + 1;
        end else if (rd) begin
            ro = tt[nt-1] + 2;
            eo = ro + 1;
        end else begin
            eo  = tt[nt-1] + N;
            nat = 1'b1;
        end

        start_addr = s;
        end_addr   = e;
        loop_en    = lp;
        start      = 1'b1;
        nxt();
        start = 1'b0;
        for (int off = 0; off <= eo + 3; off++) begin
            if (off > 0) nxt();
            pause      = (off >= pp && off < pp + pl);
            stop       = (off == so);
            rst        = (off == ro);
            start      = (off == 3);
            start_addr = 16'($urandom);
            end_addr   = 16'($urandom);
            loop_en    = 1'($urandom);
            #1;
            et = 1'b0;
            ep = SIL;
            er = 1'b0;
            ea = '0;
            for (int j = 0; j < nt; j++) begin
                if (off == tt[j]) et = 1'b1;
                if (off >= tt[j]) ep = val(ta[j]);
            end
            if (off >= eo) ep = SIL;
            for (int j = 0; j < nf; j++) begin
                if (off == rt[j] && off < eo) begin
                    er = 1'b1;
                    ea = ta[j];
                end
            end
            chk("sample_tick", off, 32'(sample_tick), 32'(et));
            chk("pwm_data", off, 32'(pwm_data), 32'(ep));
            chk("busy", off, 32'(busy), 32'(off < eo));
            chk("done", off, 32'(done), 32'(nat && off == eo));
            chk("mem_rd", off, 32'(mem_rd), 32'(er));
            if (er) chk("mem_addr", off, 32'(mem_addr), 32'(ea));
            if (rd && off == eo) chk("rst_addr", off, 32'(mem_addr), 32'd0);
        end
        pause = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        nxt();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        int span, sk, pk;
        bit lp;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        loop_en    = 1'b0;
        start_addr = '0;
        end_addr   = '0;
        repeat (3) nxt();
        chk("rst_pwm", 0, 32'(pwm_data), 32'(SIL));
        chk("rst_rd", 0, 32'(mem_rd), 32'd0);
        chk("rst_addr", 0, 32'(mem_addr), 32'd0);
        chk("rst_tick", 0, 32'(sample_tick), 32'd0);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        rst = 1'b0;
        nxt();

        // start and stop together in IDLE: stays idle
        start      = 1'b1;
        stop       = 1'b1;
        start_addr = 16'd5;
        end_addr   = 16'd6;
        nxt();
        start = 1'b0;
        stop  = 1'b0;
        #1;
        chk("ss_busy", 0, 32'(busy), 32'd0);
        chk("ss_rd", 0, 32'(mem_rd), 32'd0);
        nxt();
        chk("ss_busy2", 1, 32'(busy), 32'd0);

        play(16'd2, 16'd4, 1'b0, -1, 0, -1, 1'b0);
        play(16'd2, 16'd4, 1'b1, -1, 0, 6, 1'b0);
        play(16'd2, 16'd4, 1'b0, 0, 20, -1, 1'b0);
        play(16'd2, 16'd4, 1'b0, -1, 0, 1, 1'b0);
        play(16'hFFFF, 16'h0001, 1'b0, -1, 0, -1, 1'b0);
        play(16'd2, 16'd4, 1'b0, -1, 0, -1, 1'b1);
        play(16'd7, 16'd7, 1'b0, -1, 0, -1, 1'b0);
        play(16'd9, 16'd9, 1'b1, -1, 0, 2, 1'b0);

        for (int r = 0; r < 8; r++) begin
            s    = 16'($urandom);
            span = $urandom_range(0, 3);
            lp   = 1'($urandom);
            sk   = -1;
            pk   = -1;
            if (lp) sk = $urandom_range(span + 1, span + 3);
            else if ($urandom_range(0, 1) == 1) sk = $urandom_range(0, span);
            if ($urandom_range(0, 1) == 1 &&
                ((sk >= 0 && sk > 0) || (sk < 0 && span >= 1)))
                pk = 0;
            play(s, s + 16'(span), lp, pk, $urandom_range(1, 6), sk, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
